// File: rtl/mem_arb_ctrl_if.sv
// Bundle for the two cache-side requesters and the single-ported RAM behind mem_arb_ctrl.
// Signal names follow the cache/RAM port list so waveforms match the block diagram.
// Modports:
//   master : the arbiter view.
//            Inputs:  requests, addresses, store data, ramload, ramready.
//            Outputs: waits, loads, RAM strobes, ramaddr, ramstore.
//   slave  : the environment view (caches plus RAM model), with every direction mirrored.
interface mem_arb_ctrl_if #(
  parameter int RAM_AW = 16
);

  // Instruction cache side.
  logic              iREN;
  logic [31:0]       iaddr;
  logic              iwait;
  logic [31:0]       iload;

  // Data cache side.
  logic              dREN;
  logic              dWEN;
  logic [31:0]       daddr;
  logic [31:0]       dstore;
  logic              dwait;
  logic [31:0]       dload;

  // RAM side. ramaddr is a word address.
  logic              ramREN;
  logic              ramWEN;
  logic [RAM_AW-1:0] ramaddr;
  logic [31:0]       ramstore;
  logic [31:0]       ramload;
  logic              ramready;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arb_ctrl.sv
// Arbitrates the instruction cache and data cache onto one single-ported RAM.
// Latency: at least 2 cycles from request to completion (one IDLE grant cycle, then an access cycle with ramready).
// Backpressure: a requester is held by its wait output until the RAM asserts ramready on its access.
//
// Ports:
//   CLK  : system clock, rising edge.
//   nRST : asynchronous active-low reset.
//   bus  : mem_arb_ctrl_if.master carrying the cache requests, the waits and loads,
//          and the RAM strobes, address, data and ready.
//
// Configuration macro ROUND_ROBIN_ARB_EN:
//   undefined : fixed priority, so data wins every tie seen in IDLE.
//   defined   : a tie in IDLE goes to the requester that was not granted last.
//
// All outputs are combinational from the state and the live inputs. A requester that drops its
// request while it is being served is let go without a completion. Its strobes are 0 in that cycle.
module mem_arb_ctrl #(
  parameter int RAM_AW = 16
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arb_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              d_req;
  logic              tie_pick_d;   // 1: a simultaneous request in IDLE goes to data

  logic              ram_ren;
  logic              ram_wen;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_store;
  logic              i_wait;
  logic              d_wait;
  logic [31:0]       i_load;
  logic [31:0]       d_load;

  // A write counts as a data request even without dREN. Read plus write together is a write.
  assign d_req = bus.dREN | bus.dWEN;

  // The byte-lane bits and the bits above the RAM window never reach the RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.iaddr[31:RAM_AW+2], bus.iaddr[1:0],
                              bus.daddr[31:RAM_AW+2], bus.daddr[1:0]};

  // --------------------------------------------------------------------------
  // Tie-break selection
  // --------------------------------------------------------------------------
`ifdef ROUND_ROBIN_ARB_EN
  logic last_d;   // 1: the most recent grant went to data

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_d <= 1'b0;                      // reset as if instruction had been served last
    end else if (state == IDLE && state_nxt != IDLE) begin
      last_d <= (state_nxt == DACC);       // every grant, tie or not, updates history
    end
  end

  assign tie_pick_d = ~last_d;
`else
  assign tie_pick_d = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    i_wait    = 1'b1;
    d_wait    = 1'b1;
    i_load    = '0;
    d_load    = '0;

    case (state)
      IDLE: begin
        // No strobes in IDLE. A grant always costs one cycle here.
        if (d_req && (!bus.iREN || tie_pick_d)) begin
          state_nxt = DACC;
        end else if (bus.iREN) begin
          state_nxt = IACC;
        end
      end

      DACC: begin
        if (!d_req) begin
          // The requester walked away, so release the RAM without a completion.
          state_nxt = IDLE;
        end else begin
          ram_wen   = bus.dWEN;
          ram_ren   = bus.dREN & ~bus.dWEN;
          ram_addr  = bus.daddr[RAM_AW+1:2];
          ram_store = bus.dstore;
          if (bus.ramready) begin
            d_wait    = 1'b0;
            d_load    = bus.ramload;
            state_nxt = IDLE;
          end
        end
      end

      IACC: begin
        if (!bus.iREN) begin
          state_nxt = IDLE;
        end else begin
          ram_ren  = 1'b1;
          ram_addr = bus.iaddr[RAM_AW+1:2];
          if (bus.ramready) begin
            i_wait    = 1'b0;
            i_load    = bus.ramload;
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.iwait    = i_wait;
  assign bus.iload    = i_load;
  assign bus.dwait    = d_wait;
  assign bus.dload    = d_load;

endmodule
